// File: rtl/exc_ctrl.sv
// Exception / ERET arbiter at the commit boundary. Picks the highest-priority
// cause of a committing instruction, sends one registered capture pulse to CP0
// (or a clear_exl pulse for ERET), flushes the pipeline and holds a redirect
// request until fetch accepts it.
//
// Handshake: the redirect transfers in a cycle where redirect_valid and
// redirect_ready are both high. While redirect_valid is high, redirect_pc is
// held stable and commit_ready is low, so any commit_valid is ignored.
module exc_ctrl #(
  parameter logic [31:0] GEN_VECTOR    = 32'hBFC0_0380,
  parameter logic [31:0] REFILL_VECTOR = 32'hBFC0_0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [31:0] commit_pc,
  input  logic        commit_bd,
  input  logic        commit_eret,
  input  logic        f_adel,
  input  logic        f_tlb_miss,
  input  logic        f_tlb_inv,
  input  logic        ri,
  input  logic        sys,
  input  logic        brk,
  input  logic        ov,
  input  logic        d_adel,
  input  logic        d_ades,
  input  logic        d_tlb_miss,
  input  logic        d_tlb_inv,
  input  logic        d_mod,
  input  logic        d_store,
  input  logic [31:0] d_vaddr,
  input  logic        allow_int,
  input  logic [7:0]  interrupt_flag,
  input  logic        in_exl,
  input  logic [31:0] epc_i,
  output logic        exp_en,
  output logic        exp_bd,
  output logic [31:0] exp_epc,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_badvaddr,
  output logic        exp_badvaddr_we,
  output logic        clear_exl,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        exp_en_q, exp_en_d;
  logic        clear_exl_q, clear_exl_d;
  logic        flush_q, flush_d;
  logic        exp_bd_q, exp_bd_d;
  logic [31:0] exp_epc_q, exp_epc_d;
  logic [4:0]  exp_code_q, exp_code_d;
  logic [31:0] exp_badvaddr_q, exp_badvaddr_d;
  logic        exp_badvaddr_we_q, exp_badvaddr_we_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        int_pend;
  logic        cause_exc;
  logic [4:0]  cause_code;
  logic        cause_bad_we;
  logic [31:0] cause_bad;
  logic        cause_refill;

  assign int_pend = allow_int & (|interrupt_flag);

  // Priority decode of the committing instruction's exception cause
  always_comb begin
    cause_exc    = 1'b1;
    cause_code   = 5'd0;
    cause_bad_we = 1'b0;
    cause_bad    = 32'd0;
    cause_refill = 1'b0;
    if (int_pend) begin
      cause_code = 5'd0;
    end else if (f_adel) begin
      cause_code   = 5'd4;
      cause_bad_we = 1'b1;
      cause_bad    = commit_pc;
    end else if (f_tlb_miss || f_tlb_inv) begin
      cause_code   = 5'd2;
      cause_bad_we = 1'b1;
      cause_bad    = commit_pc;
      cause_refill = f_tlb_miss;
    end else if (ri) begin
      cause_code = 5'd10;
    end else if (sys) begin
      cause_code = 5'd8;
    end else if (brk) begin
      cause_code = 5'd9;
    end else if (ov) begin
      cause_code = 5'd12;
    end else if (d_adel || d_ades) begin
      cause_code   = d_adel ? 5'd4 : 5'd5;
      cause_bad_we = 1'b1;
      cause_bad    = d_vaddr;
    end else if (d_tlb_miss || d_tlb_inv) begin
      cause_code   = d_store ? 5'd3 : 5'd2;
      cause_bad_we = 1'b1;
      cause_bad    = d_vaddr;
      cause_refill = d_tlb_miss;
    end else if (d_mod) begin
      cause_code   = 5'd1;
      cause_bad_we = 1'b1;
      cause_bad    = d_vaddr;
    end else begin
      cause_exc = 1'b0;
    end
  end

  // Next-state and registered output computation
  always_comb begin
    state_d           = state_q;
    exp_en_d          = 1'b0;
    clear_exl_d       = 1'b0;
    flush_d           = 1'b0;
    exp_badvaddr_we_d = 1'b0;
    exp_bd_d          = exp_bd_q;
    exp_epc_d         = exp_epc_q;
    exp_code_d        = exp_code_q;
    exp_badvaddr_d    = exp_badvaddr_q;
    redirect_pc_d     = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (commit_valid && (cause_exc || commit_eret)) begin
          state_d = REDIR;
          flush_d = 1'b1;
          if (cause_exc) begin
            exp_en_d          = 1'b1;
            exp_code_d        = cause_code;
            exp_epc_d         = commit_pc;
            exp_bd_d          = commit_bd;
            exp_badvaddr_we_d = cause_bad_we;
            if (cause_bad_we) exp_badvaddr_d = cause_bad;
            redirect_pc_d     = (cause_refill && !in_exl) ? REFILL_VECTOR : GEN_VECTOR;
          end else begin
            clear_exl_d   = 1'b1;
            redirect_pc_d = epc_i;
          end
        end
      end
      REDIR: begin
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      exp_en_q          <= 1'b0;
      clear_exl_q       <= 1'b0;
      flush_q           <= 1'b0;
      exp_bd_q          <= 1'b0;
      exp_epc_q         <= 32'd0;
      exp_code_q        <= 5'd0;
      exp_badvaddr_q    <= 32'd0;
      exp_badvaddr_we_q <= 1'b0;
      redirect_pc_q     <= 32'd0;
    end else begin
      state_q           <= state_d;
      exp_en_q          <= exp_en_d;
      clear_exl_q       <= clear_exl_d;
      flush_q           <= flush_d;
      exp_bd_q          <= exp_bd_d;
      exp_epc_q         <= exp_epc_d;
      exp_code_q        <= exp_code_d;
      exp_badvaddr_q    <= exp_badvaddr_d;
      exp_badvaddr_we_q <= exp_badvaddr_we_d;
      redirect_pc_q     <= redirect_pc_d;
    end
  end

  assign commit_ready    = (state_q == IDLE);
  assign redirect_valid  = (state_q == REDIR);
  assign redirect_pc     = redirect_pc_q;
  assign exp_en          = exp_en_q;
  assign clear_exl       = clear_exl_q;
  assign flush           = flush_q;
  assign exp_bd          = exp_bd_q;
  assign exp_epc         = exp_epc_q;
  assign exp_code        = exp_code_q;
  assign exp_badvaddr    = exp_badvaddr_q;
  assign exp_badvaddr_we = exp_badvaddr_we_q;

endmodule
